vga_square_ctrl: RTL and testbench
==================================

VGA_SQUARE_CTRL -- requirements
Module: vga_square_ctrl

Interface
REQ-001 The block SHALL have parameter STEP, default 2, meaning square displacement in pixels per frame per held button.
REQ-002 The block SHALL have parameter SIZE, default 32, meaning square edge length in pixels (even, 2..478).
REQ-003 The block SHALL have port clk, input, 1, meaning the single 100 MHz system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, meaning reset; rst is asynchronous and active-high.
REQ-005 The block SHALL have ports B_Up, B_Down, B_Left, B_Right, B_Center, each input, 1, meaning raw asynchronous push-buttons, active-high.
REQ-006 The block SHALL have ports vgaRed, vgaGreen, vgaBlue, each output, 1, meaning registered pixel colour.
REQ-007 The block SHALL have ports Hsync, Vsync, each output, 1, meaning registered sync signals, active-low.

Function
REQ-008 A 2-bit divider SHALL count 0..3 on every clk; pix_tick is asserted when it equals 3, which is one clk in four (25 MHz pixel rate).
REQ-009 hcount (10 bits) SHALL advance only on pix_tick and wrap from 799 to 0.
REQ-010 vcount (10 bits) SHALL advance only on a pix_tick where hcount wraps, and SHALL wrap from 524 to 0.
REQ-011 Hsync SHALL be 0 exactly when hcount is in 656..751, else 1.
REQ-012 Vsync SHALL be 0 exactly when vcount is in 490..491, else 1.
REQ-013 visible SHALL be true when hcount<640 and vcount<480.
REQ-014 Outputs SHALL be registered from the current hcount/vcount/x/y, giving a latency of exactly one clk after the counter edge.
REQ-015 Colour when visible and the pixel is inside the square (x<=hcount<x+SIZE, y<=vcount<y+SIZE): R=G=B=1.
REQ-016 Colour when visible and the pixel is outside the square: R=0, G=0, B=1.
REQ-017 Colour when not visible: R=G=B=0.
REQ-018 Each button SHALL pass through a 2-flop synchronizer; only synchronized values are used.
REQ-019 Square position x (10 bits) and y (9 bits) SHALL update only at frame event, defined as pix_tick with hcount==799 and vcount==479, i.e. entering vertical blank; they never change during visible lines.
REQ-020 At frame event, if Center is high, x SHALL become (640-SIZE)/2 and y SHALL become (480-SIZE)/2, and all direction buttons are ignored.
REQ-021 Otherwise, Left-only SHALL give x=max(x-STEP,0).
REQ-022 Otherwise, Right-only SHALL give x=min(x+STEP,640-SIZE).
REQ-023 Left and Right both high SHALL leave x unchanged.
REQ-024 Otherwise, Up-only SHALL give y=max(y-STEP,0).
REQ-025 Otherwise, Down-only SHALL give y=min(y+STEP,480-SIZE).
REQ-026 Up and Down both high SHALL leave y unchanged.
REQ-027 Horizontal and vertical moves SHALL apply in the same frame event, giving diagonal motion.
REQ-028 Clamp arithmetic SHALL use at least 11-bit intermediates; no underflow or overflow wrap is permitted.

Reset
REQ-029 While rst is high, the divider, hcount and vcount SHALL be 0, Hsync=Vsync=1, R=G=B=0, and synchronizer flops SHALL be 0.
REQ-030 While rst is high, x SHALL be (640-SIZE)/2 (304 at default) and y SHALL be (480-SIZE)/2 (224 at default).
REQ-031 Reset asserted mid-frame SHALL force these values immediately, without waiting for clk.
REQ-032 After deassertion, the first pix_tick SHALL occur on the 4th clk edge, and scanning SHALL restart at hcount=0, vcount=0.

Verification
REQ-033 Scenario 1: reset then free-run 2 frames -> Hsync period 3200 clk with a low width of 384 clk; Vsync period 1,680,000 clk with a low width of 6400 clk.
REQ-034 Scenario 2: no buttons, sample pixel (hcount=320,vcount=240) -> R=G=B=1; sample (hcount=0,vcount=0) -> R=G=0, B=1; sample (hcount=700,vcount=100) -> all 0.
REQ-035 Scenario 3: Right held for 200 frames -> x increments by 2 per frame and saturates at 608; x is never above 608; y stays at 224.
REQ-036 Scenario 4: Up+Down+Left held together for 3 frames from reset -> y=224 and x=298; then Center+Right for 1 frame -> x=304, y=224.
REQ-037 Scenario 5: Left pulsed high during visible lines only, released before frame event -> x unchanged; a pulse spanning the frame event -> exactly one 2-pixel step.
REQ-038 Scenario 6: rst asserted at hcount=400, vcount=300 after moving the square -> outputs reach reset values asynchronously, x/y return to 304/224, and the next frame timing matches Scenario 1.

Source files
------------

// File: rtl/vga_square_ctrl.sv
// rtl/vga_square_ctrl.sv - 640x480@60 VGA timing generator drawing a button-driven square
// Counters run at clk/4; all outputs are registered one clk after the counters they decode.
module vga_square_ctrl #(
    parameter int STEP = 2,
    parameter int SIZE = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic B_Up,
    input  logic B_Down,
    input  logic B_Left,
    input  logic B_Right,
    input  logic B_Center,
    output logic vgaRed,
    output logic vgaGreen,
    output logic vgaBlue,
    output logic Hsync,
    output logic Vsync
);
    localparam logic [9:0]  H_LAST   = 10'd799;
    localparam logic [9:0]  V_LAST   = 10'd524;
    localparam logic [9:0]  H_VIS    = 10'd640;
    localparam logic [9:0]  V_VIS    = 10'd480;
    localparam logic [9:0]  V_FRAME  = 10'd479;
    localparam logic [9:0]  HS_FIRST = 10'd656;
    localparam logic [9:0]  HS_LAST  = 10'd751;
    localparam logic [9:0]  VS_FIRST = 10'd490;
    localparam logic [9:0]  VS_LAST  = 10'd491;
    localparam logic [9:0]  X_MAX    = 10'(640 - SIZE);
    localparam logic [8:0]  Y_MAX    = 9'(480 - SIZE);
    localparam logic [9:0]  X_HOME   = 10'((640 - SIZE) / 2);
    localparam logic [8:0]  Y_HOME   = 9'((480 - SIZE) / 2);
    localparam logic [10:0] STEP_W   = 11'(STEP);
    localparam logic [10:0] SIZE_W   = 11'(SIZE);

    logic [1:0] div_q;
    logic       pix_tick;
    logic [9:0] hcount_q, hcount_d;
    logic [9:0] vcount_q, vcount_d;
    logic [4:0] btn_meta_q, btn_sync_q;
    logic       btn_up, btn_down, btn_left, btn_right, btn_center;
    logic       frame_evt;
    logic [9:0] x_q, x_d;
    logic [8:0] y_q, y_d;
    logic       visible, in_square;
    logic       red_d, green_d, blue_d, hsync_d, vsync_d;
    logic       red_q, green_q, blue_q, hsync_q, vsync_q;

    assign pix_tick  = (div_q == 2'd3);
    assign {btn_center, btn_right, btn_left, btn_down, btn_up} = btn_sync_q;
    // Position only moves when entering vertical blank, so a frame never tears.
    assign frame_evt = pix_tick && (hcount_q == H_LAST) && (vcount_q == V_FRAME);

    always_comb begin
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (pix_tick) begin
            if (hcount_q == H_LAST) begin
                hcount_d = 10'd0;
                vcount_d = (vcount_q == V_LAST) ? 10'd0 : vcount_q + 10'd1;
            end else begin
                hcount_d = hcount_q + 10'd1;
            end
        end
    end

    // Clamps are evaluated in 11 bits so neither edge of the screen can wrap.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (frame_evt) begin
            if (btn_center) begin
                x_d = X_HOME;
                y_d = Y_HOME;
            end else begin
                if (btn_left && !btn_right)
                    x_d = (11'(x_q) < STEP_W) ? 10'd0 : 10'(11'(x_q) - STEP_W);
                else if (btn_right && !btn_left)
                    x_d = (11'(x_q) + STEP_W > 11'(X_MAX)) ? X_MAX : 10'(11'(x_q) + STEP_W);
                if (btn_up && !btn_down)
                    y_d = (11'(y_q) < STEP_W) ? 9'd0 : 9'(11'(y_q) - STEP_W);
                else if (btn_down && !btn_up)
                    y_d = (11'(y_q) + STEP_W > 11'(Y_MAX)) ? Y_MAX : 9'(11'(y_q) + STEP_W);
            end
        end
    end

    assign visible   = (hcount_q < H_VIS) && (vcount_q < V_VIS);
    assign in_square = (hcount_q >= x_q) && (11'(hcount_q) < 11'(x_q) + SIZE_W) &&
                       (vcount_q >= 10'(y_q)) && (11'(vcount_q) < 11'(y_q) + SIZE_W);
    assign red_d     = visible && in_square;
    assign green_d   = visible && in_square;
    assign blue_d    = visible;
    assign hsync_d   = !((hcount_q >= HS_FIRST) && (hcount_q <= HS_LAST));
    assign vsync_d   = !((vcount_q >= VS_FIRST) && (vcount_q <= VS_LAST));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q      <= 2'd0;
            hcount_q   <= 10'd0;
            vcount_q   <= 10'd0;
            btn_meta_q <= 5'd0;
            btn_sync_q <= 5'd0;
            x_q        <= X_HOME;
            y_q        <= Y_HOME;
            red_q      <= 1'b0;
            green_q    <= 1'b0;
            blue_q     <= 1'b0;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
        end else begin
            div_q      <= div_q + 2'd1;
            hcount_q   <= hcount_d;
            vcount_q   <= vcount_d;
            btn_meta_q <= {B_Center, B_Right, B_Left, B_Down, B_Up};
            btn_sync_q <= btn_meta_q;
            x_q        <= x_d;
            y_q        <= y_d;
            red_q      <= red_d;
            green_q    <= green_d;
            blue_q     <= blue_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
        end
    end

    assign vgaRed   = red_q;
    assign vgaGreen = green_q;
    assign vgaBlue  = blue_q;
    assign Hsync    = hsync_q;
    assign Vsync    = vsync_q;
endmodule

// File: tb/tb_vga_square_ctrl.sv
// tb/tb_vga_square_ctrl.sv - directed bench for vga_square_ctrl
// Scan position is relocated by forcing the counters so whole frames need not be simulated.
module tb_vga_square_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic B_Up, B_Down, B_Left, B_Right, B_Center;
    logic vgaRed, vgaGreen, vgaBlue, Hsync, Vsync;

    int n_vec = 0;
    int n_err = 0;
    int lw, per, ex, ey;
    logic [9:0] jh, jv;

    vga_square_ctrl dut (
        .clk(clk), .rst(rst),
        .B_Up(B_Up), .B_Down(B_Down), .B_Left(B_Left), .B_Right(B_Right), .B_Center(B_Center),
        .vgaRed(vgaRed), .vgaGreen(vgaGreen), .vgaBlue(vgaBlue),
        .Hsync(Hsync), .Vsync(Vsync)
    );

    always #5 clk = ~clk;

    task chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task jump(input logic [9:0] h, input logic [9:0] v);
        jh = h;
        jv = v;
        @(negedge clk);
        force dut.div_q = 2'd0;
        force dut.hcount_q = jh;
        force dut.vcount_q = jv;
        #1;
        release dut.div_q;
        release dut.hcount_q;
        release dut.vcount_q;
    endtask

    // Eight clks from (798,479) with the divider at 0 land just after the frame event.
    task frame_evt();
        jump(10'd798, 10'd479);
        step(8);
    endtask

    task pix(input string tag, input logic [9:0] h, input logic [9:0] v, input logic [4:0] exp);
        jump(h, v);
        step(1);
        chk(tag, 32'({vgaRed, vgaGreen, vgaBlue, Hsync, Vsync}), 32'(exp));
    endtask

    task measure(input bit use_v, input bit need_period, input int budget,
                 output int low_w, output int period);
        int t_fall1, t_rise, t_fall2;
        logic prev, cur;
        t_fall1 = -1; t_rise = -1; t_fall2 = -1;
        prev = use_v ? Vsync : Hsync;
        for (int c = 1; c <= budget; c++) begin
            @(posedge clk);
            #1;
            cur = use_v ? Vsync : Hsync;
            if (prev && !cur) begin
                if (t_fall1 < 0) t_fall1 = c;
                else if (t_fall2 < 0) t_fall2 = c;
            end
            if (!prev && cur && t_fall1 >= 0 && t_rise < 0) t_rise = c;
            prev = cur;
            if (need_period ? (t_fall2 >= 0) : (t_rise >= 0)) break;
        end
        low_w  = (t_rise >= 0) ? t_rise - t_fall1 : -1;
        period = (t_fall2 >= 0) ? t_fall2 - t_fall1 : -1;
    endtask

    initial begin
        rst = 1'b1;
        {B_Up, B_Down, B_Left, B_Right, B_Center} = 5'b10000;
        step(3);
        chk("rst_out", 32'({vgaRed, vgaGreen, vgaBlue, Hsync, Vsync}), 32'b00011);
        chk("rst_div", 32'(dut.div_q), 0);
        chk("rst_hcount", 32'(dut.hcount_q), 0);
        chk("rst_vcount", 32'(dut.vcount_q), 0);
        chk("rst_x", 32'(dut.x_q), 304);
        chk("rst_y", 32'(dut.y_q), 224);
        chk("rst_sync", 32'({dut.btn_meta_q, dut.btn_sync_q}), 0);
        B_Up = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step(3);
        chk("first_tick_h3", 32'(dut.hcount_q), 0);
        step(1);
        chk("first_tick_h4", 32'(dut.hcount_q), 1);
        chk("first_tick_v4", 32'(dut.vcount_q), 0);

        measure(1'b0, 1'b1, 8000, lw, per);
        chk("hs_low", 32'(lw), 384);
        chk("hs_period", 32'(per), 3200);
        jump(10'd780, 10'd489);
        measure(1'b1, 1'b0, 8000, lw, per);
        chk("vs_low", 32'(lw), 6400);

        jump(10'd5, 10'd5);
        step(3);
        chk("no_tick_h", 32'(dut.hcount_q), 5);
        step(1);
        chk("tick_h", 32'(dut.hcount_q), 6);
        jump(10'd500, 10'd10);
        step(4);
        chk("mid_line_v", 32'(dut.vcount_q), 10);
        jump(10'd799, 10'd523);
        step(4);
        chk("hwrap_h", 32'(dut.hcount_q), 0);
        chk("hwrap_v", 32'(dut.vcount_q), 524);
        jump(10'd799, 10'd524);
        step(4);
        chk("vwrap_h", 32'(dut.hcount_q), 0);
        chk("vwrap_v", 32'(dut.vcount_q), 0);

        pix("px_center",  10'd320, 10'd240, 5'b11111);
        pix("px_origin",  10'd0,   10'd0,   5'b00111);
        pix("px_blank",   10'd700, 10'd100, 5'b00001);
        pix("sq_left_o",  10'd303, 10'd240, 5'b00111);
        pix("sq_left_i",  10'd304, 10'd240, 5'b11111);
        pix("sq_right_i", 10'd335, 10'd240, 5'b11111);
        pix("sq_right_o", 10'd336, 10'd240, 5'b00111);
        pix("sq_top_o",   10'd320, 10'd223, 5'b00111);
        pix("sq_top_i",   10'd320, 10'd224, 5'b11111);
        pix("sq_bot_i",   10'd320, 10'd255, 5'b11111);
        pix("sq_bot_o",   10'd320, 10'd256, 5'b00111);
        pix("hs_655",     10'd655, 10'd0,   5'b00011);
        pix("hs_656",     10'd656, 10'd0,   5'b00001);
        pix("hs_751",     10'd751, 10'd0,   5'b00001);
        pix("hs_752",     10'd752, 10'd0,   5'b00011);
        pix("vs_489",     10'd0,   10'd489, 5'b00011);
        pix("vs_490",     10'd0,   10'd490, 5'b00010);
        pix("vs_491",     10'd0,   10'd491, 5'b00010);
        pix("vs_492",     10'd0,   10'd492, 5'b00011);
        pix("vis_h639",   10'd639, 10'd0,   5'b00111);
        pix("vis_h640",   10'd640, 10'd0,   5'b00011);
        pix("vis_v479",   10'd0,   10'd479, 5'b00111);
        pix("vis_v480",   10'd0,   10'd480, 5'b00011);

        {B_Up, B_Down, B_Left, B_Right, B_Center} = 5'b11100;
        for (int k = 1; k <= 3; k++) begin
            frame_evt();
            chk("udl_x", 32'(dut.x_q), 32'(304 - 2 * k));
            chk("udl_y", 32'(dut.y_q), 224);
        end
        {B_Up, B_Down, B_Left, B_Right, B_Center} = 5'b00011;
        frame_evt();
        chk("ctr_x", 32'(dut.x_q), 304);
        chk("ctr_y", 32'(dut.y_q), 224);

        {B_Up, B_Down, B_Left, B_Right, B_Center} = 5'b00000;
        frame_evt();
        jump(10'd100, 10'd100);
        B_Left = 1'b1;
        step(40);
        chk("vis_left_x", 32'(dut.x_q), 304);
        B_Left = 1'b0;
        step(5);
        frame_evt();
        chk("pulse_vis_x", 32'(dut.x_q), 304);
        B_Left = 1'b1;
        frame_evt();
        B_Left = 1'b0;
        chk("pulse_evt_x", 32'(dut.x_q), 302);
        frame_evt();
        chk("pulse_after_x", 32'(dut.x_q), 302);

        B_Right = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            frame_evt();
            ex = 302 + 2 * k;
            if (ex > 608) ex = 608;
            chk("right_x", 32'(dut.x_q), 32'(ex));
            chk("right_y", 32'(dut.y_q), 224);
        end
        B_Right = 1'b0;

        {B_Up, B_Left} = 2'b11;
        for (int k = 1; k <= 320; k++) begin
            frame_evt();
            ex = 608 - 2 * k;
            if (ex < 0) ex = 0;
            ey = 224 - 2 * k;
            if (ey < 0) ey = 0;
            chk("diag_x", 32'(dut.x_q), 32'(ex));
            chk("diag_y", 32'(dut.y_q), 32'(ey));
        end
        {B_Up, B_Left} = 2'b00;

        B_Down = 1'b1;
        for (int k = 1; k <= 240; k++) begin
            frame_evt();
            ey = 2 * k;
            if (ey > 448) ey = 448;
            chk("down_y", 32'(dut.y_q), 32'(ey));
            chk("down_x", 32'(dut.x_q), 0);
        end
        B_Down = 1'b0;

        jump(10'd400, 10'd300);
        step(1);
        chk("pre_rst_rgb", 32'({vgaRed, vgaGreen, vgaBlue}), 32'b001);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out", 32'({vgaRed, vgaGreen, vgaBlue, Hsync, Vsync}), 32'b00011);
        chk("arst_h", 32'(dut.hcount_q), 0);
        chk("arst_v", 32'(dut.vcount_q), 0);
        chk("arst_div", 32'(dut.div_q), 0);
        chk("arst_x", 32'(dut.x_q), 304);
        chk("arst_y", 32'(dut.y_q), 224);
        step(2);
        @(negedge clk);
        rst = 1'b0;
        measure(1'b0, 1'b1, 8000, lw, per);
        chk("hs_low_2", 32'(lw), 384);
        chk("hs_period_2", 32'(per), 3200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
